// File: rtl/pipelined_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_alu_if
// Description : Bundle of the pipelined ALU's operand/control input channel,
//               result output channel and status outputs.
//               The master drives operands and consumes results; the slave
//               is the ALU itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_alu_if #(
    parameter int WIDTH = 16
);
    // Input channel: operands and Hack control bits
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;

    // Output channel: result and flags
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             cy;
    logic             ov;

    // Number of results consumed so far (wraps)
    logic [WIDTH-1:0] op_count;

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
        input  in_ready, out_valid, out, zr, ng, cy, ov, op_count
    );

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
        output in_ready, out_valid, out, zr, ng, cy, ov, op_count
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_alu.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_alu
// Description : Two-stage valid/ready pipelined Hack ALU with carry and signed
//               overflow flags and a count of consumed results.
//               Stage 1 registers the preprocessed operands (zero/negate),
//               stage 2 registers the function result and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_alu #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipelined_alu_if.slave bus
);

    localparam logic [WIDTH-1:0] c_count_one = {{(WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_xs;
    logic [WIDTH-1:0] r_s1_ys;
    logic             r_s1_f;
    logic             r_s1_no;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_out;
    logic             r_s2_zr;
    logic             r_s2_ng;
    logic             r_s2_cy;
    logic             r_s2_ov;

    logic [WIDTH-1:0] r_op_count;

    // ------------------------------------------------------------------
    // Handshake / advance conditions
    // ------------------------------------------------------------------
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_in_xfer;
    logic w_out_xfer;

    // Stage 2 may load when empty or when its result is being consumed;
    // stage 1 may load when empty or when stage 2 is moving on, so a full
    // pipe still accepts a new operation on the same edge it drains one.
    always_comb begin
        w_s2_adv   = ~r_s2_valid | bus.out_ready;
        w_s1_adv   = ~r_s1_valid | w_s2_adv;
        w_in_xfer  = bus.in_valid & w_s1_adv;
        w_out_xfer = r_s2_valid & bus.out_ready;
    end

    // ------------------------------------------------------------------
    // Operand preprocessing (feeds stage 1)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_xs;
    logic [WIDTH-1:0] w_ys;

    // Zero then optionally invert each operand
    always_comb begin
        w_xs = bus.zx ? '0 : bus.x;
        w_ys = bus.zy ? '0 : bus.y;
        if (bus.nx) begin
            w_xs = ~w_xs;
        end
        if (bus.ny) begin
            w_ys = ~w_ys;
        end
    end

    // Stage 1: capture preprocessed operands and function controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_xs    <= '0;
            r_s1_ys    <= '0;
            r_s1_f     <= 1'b0;
            r_s1_no    <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            // Data only moves on a real transfer; idle inputs are ignored
            if (bus.in_valid) begin
                r_s1_xs <= w_xs;
                r_s1_ys <= w_ys;
                r_s1_f  <= bus.f;
                r_s1_no <= bus.no;
            end
        end
    end

    // ------------------------------------------------------------------
    // Function and flags (feeds stage 2)
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_res;
    logic             w_cy;
    logic             w_ov;
    logic             w_zr;
    logic             w_ng;

    // Carry and overflow are taken from the raw function result, before the
    // optional output inversion; in AND mode both are forced to zero.
    always_comb begin
        w_sum = {1'b0, r_s1_xs} + {1'b0, r_s1_ys};
        w_r   = r_s1_f ? w_sum[WIDTH-1:0] : (r_s1_xs & r_s1_ys);
        w_res = r_s1_no ? ~w_r : w_r;
        w_cy  = r_s1_f & w_sum[WIDTH];
        w_ov  = r_s1_f
              & (r_s1_xs[WIDTH-1] == r_s1_ys[WIDTH-1])
              & (w_r[WIDTH-1] != r_s1_xs[WIDTH-1]);
        w_zr  = (w_res == '0);
        w_ng  = w_res[WIDTH-1];
    end

    // Stage 2: register result and flags; they hold while output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_out   <= '0;
            r_s2_zr    <= 1'b0;
            r_s2_ng    <= 1'b0;
            r_s2_cy    <= 1'b0;
            r_s2_ov    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_out <= w_res;
                r_s2_zr  <= w_zr;
                r_s2_ng  <= w_ng;
                r_s2_cy  <= w_cy;
                r_s2_ov  <= w_ov;
            end
        end
    end

    // Count consumed results, wrapping naturally at 2^WIDTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_out_xfer) begin
            r_op_count <= r_op_count + c_count_one;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // in_ready depends only on pipeline state and out_ready, never in_valid
    always_comb begin
        bus.in_ready  = w_s1_adv;
        bus.out_valid = r_s2_valid;
        bus.out       = r_s2_out;
        bus.zr        = r_s2_zr;
        bus.ng        = r_s2_ng;
        bus.cy        = r_s2_cy;
        bus.ov        = r_s2_ov;
        bus.op_count  = r_op_count;
    end

    // w_in_xfer documents the accept condition; fold it into a no-op use
    logic w_unused;
    always_comb begin
        w_unused = w_in_xfer;
    end

endmodule
`default_nettype wire
